// File: rtl/lcd_pwm_decoder.sv
// lcd_pwm_decoder: measures a backlight PWM waveform and recovers its 1/10/20..100 brightness code.
// Define LCD_PWM_RAW_EN to add the duty_raw/period_raw snapshot outputs.

module lcd_pwm_decoder #(
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_in,
  output logic [7:0]       light_scale,
  output logic             scale_valid,
  output logic             timeout,
  output logic             overrun
`ifdef LCD_PWM_RAW_EN
  ,
  output logic [CNT_W-1:0] duty_raw,
  output logic [CNT_W-1:0] period_raw
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MEAS   = 2'd1;
  localparam logic [1:0] S_QUANT  = 2'd2;
  localparam logic [1:0] S_STATIC = 2'd3;

  localparam int               CMP_W      = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT);
  // Input must look static for TIMEOUT cycles at the synchronizer output, hence the +2.
  localparam logic [CNT_W:0]   IDLE_LIMIT = (CNT_W + 1)'(TIMEOUT + 2);

  logic             sync1_reg, sync2_reg, prev_reg;
  logic             rise;
  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] per_cnt_reg, per_cnt_next;
  logic [CNT_W-1:0] hi_cnt_reg, hi_cnt_next;
  logic [CNT_W-1:0] per_s_reg, per_s_next;
  logic [CNT_W-1:0] hi_s_reg, hi_s_next;
  logic [3:0]       k_reg, k_next;
  logic [CNT_W:0]   idle_cnt_reg, idle_cnt_next;
  logic [7:0]       light_scale_reg, light_scale_next;
  logic             scale_valid_reg, scale_valid_next;
  logic             timeout_reg, timeout_next;
  logic             overrun_reg, overrun_next;
`ifdef LCD_PWM_RAW_EN
  logic [CNT_W-1:0] duty_raw_reg, duty_raw_next;
  logic [CNT_W-1:0] period_raw_reg, period_raw_next;
`endif

  logic [4:0]       odd_mult;
  logic [CMP_W-1:0] hi_x20;
  logic [CMP_W-1:0] per_xodd;
  logic             step_ok;
  logic [7:0]       k_code;
  logic             go_static;

  assign rise = sync2_reg & ~prev_reg;

  // Duty >= (2k+1)/20 means the nearest decade is above k; ties land on the upper decade.
  assign odd_mult = {k_reg, 1'b1};
  assign hi_x20   = CMP_W'(hi_s_reg) * CMP_W'(5'd20);
  assign per_xodd = CMP_W'(per_s_reg) * CMP_W'(odd_mult);
  assign step_ok  = (k_reg < 4'd10) && (hi_x20 >= per_xodd);
  assign k_code   = (k_reg == 4'd0) ? 8'd1 : 8'({4'd0, k_reg} * 8'd10);

  always_comb begin
    state_next       = state_reg;
    per_cnt_next     = per_cnt_reg;
    hi_cnt_next      = hi_cnt_reg;
    per_s_next       = per_s_reg;
    hi_s_next        = hi_s_reg;
    k_next           = k_reg;
    idle_cnt_next    = idle_cnt_reg;
    light_scale_next = light_scale_reg;
    scale_valid_next = 1'b0;
    timeout_next     = timeout_reg;
    overrun_next     = overrun_reg;
    go_static        = 1'b0;
`ifdef LCD_PWM_RAW_EN
    duty_raw_next    = duty_raw_reg;
    period_raw_next  = period_raw_reg;
`endif

    if (rise) begin
      per_cnt_next = CNT_W'(1);
      hi_cnt_next  = CNT_W'(1);
    end else begin
      if (per_cnt_reg < CNT_MAX) per_cnt_next = per_cnt_reg + CNT_W'(1);
      if (sync2_reg && (hi_cnt_reg < CNT_MAX)) hi_cnt_next = hi_cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (rise) begin
          state_next = S_MEAS;
        end else begin
          per_cnt_next = '0;
          hi_cnt_next  = '0;
          if (idle_cnt_reg == IDLE_LIMIT) go_static = 1'b1;
          else idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      S_MEAS: begin
        if (rise) begin
          hi_s_next  = hi_cnt_reg;
          per_s_next = per_cnt_reg;
          k_next     = 4'd0;
          state_next = S_QUANT;
        end else if (per_cnt_reg == CNT_MAX) begin
          go_static = 1'b1;
        end
      end
      S_QUANT: begin
        // A new edge here cannot be snapshotted; the counters restart and the old result finishes.
        if (rise) overrun_next = 1'b1;
        if (step_ok) begin
          k_next = k_reg + 4'd1;
        end else begin
          state_next       = S_MEAS;
          light_scale_next = k_code;
          scale_valid_next = 1'b1;
`ifdef LCD_PWM_RAW_EN
          duty_raw_next    = hi_s_reg;
          period_raw_next  = per_s_reg;
`endif
        end
      end
      default: begin
        if (rise) begin
          timeout_next = 1'b0;
          state_next   = S_MEAS;
        end else begin
          per_cnt_next = '0;
          hi_cnt_next  = '0;
        end
      end
    endcase

    if (go_static) begin
      state_next       = S_STATIC;
      per_cnt_next     = '0;
      hi_cnt_next      = '0;
      light_scale_next = sync2_reg ? 8'd100 : 8'd1;
      scale_valid_next = 1'b1;
      timeout_next     = 1'b1;
`ifdef LCD_PWM_RAW_EN
      duty_raw_next    = '0;
      period_raw_next  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg       <= 1'b0;
      sync2_reg       <= 1'b0;
      prev_reg        <= 1'b0;
      state_reg       <= S_IDLE;
      per_cnt_reg     <= '0;
      hi_cnt_reg      <= '0;
      per_s_reg       <= '0;
      hi_s_reg        <= '0;
      k_reg           <= 4'd0;
      idle_cnt_reg    <= '0;
      light_scale_reg <= 8'd20;
      scale_valid_reg <= 1'b0;
      timeout_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
`ifdef LCD_PWM_RAW_EN
      duty_raw_reg    <= '0;
      period_raw_reg  <= '0;
`endif
    end else begin
      sync1_reg       <= pwm_in;
      sync2_reg       <= sync1_reg;
      prev_reg        <= sync2_reg;
      state_reg       <= state_next;
      per_cnt_reg     <= per_cnt_next;
      hi_cnt_reg      <= hi_cnt_next;
      per_s_reg       <= per_s_next;
      hi_s_reg        <= hi_s_next;
      k_reg           <= k_next;
      idle_cnt_reg    <= idle_cnt_next;
      light_scale_reg <= light_scale_next;
      scale_valid_reg <= scale_valid_next;
      timeout_reg     <= timeout_next;
      overrun_reg     <= overrun_next;
`ifdef LCD_PWM_RAW_EN
      duty_raw_reg    <= duty_raw_next;
      period_raw_reg  <= period_raw_next;
`endif
    end
  end

  assign light_scale = light_scale_reg;
  assign scale_valid = scale_valid_reg;
  assign timeout     = timeout_reg;
  assign overrun     = overrun_reg;
`ifdef LCD_PWM_RAW_EN
  assign duty_raw    = duty_raw_reg;
  assign period_raw  = period_raw_reg;
`endif

endmodule

// File: tb/tb_lcd_pwm_decoder.sv
// Directed bench for lcd_pwm_decoder: a cycle-counting PWM model queues expected codes,
// and a negedge monitor pops and compares them on every scale_valid pulse.

module tb_lcd_pwm_decoder;
  localparam int CNT_W   = 12;
  localparam int TIMEOUT = 4095;

  logic             clk = 1'b0;
  logic             reset;
  logic             pwm_in;
  logic [7:0]       light_scale;
  logic             scale_valid;
  logic             timeout;
  logic             overrun;
`ifdef LCD_PWM_RAW_EN
  logic [CNT_W-1:0] duty_raw;
  logic [CNT_W-1:0] period_raw;
`endif

  lcd_pwm_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .light_scale (light_scale),
    .scale_valid (scale_valid),
    .timeout     (timeout),
    .overrun     (overrun)
`ifdef LCD_PWM_RAW_EN
    ,
    .duty_raw    (duty_raw),
    .period_raw  (period_raw)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   sb_ignore = 1'b0;
  int   cyc = 0;
  int   last_valid_cyc = -1;
  int   prev_valid_cyc = -1;

  // PWM model state: cycles and high cycles since the last driven rising edge.
  bit   model_on   = 1'b1;
  bit   model_meas = 1'b0;
  bit   pwm_last   = 1'b0;
  int   per_m = 0;
  int   hi_m  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] expected_code(input int h, input int p);
    int c;
    c = (20 * h + p) / (2 * p);
    if (c > 10) c = 10;
    return (c == 0) ? 8'd1 : 8'(10 * c);
  endfunction

  always @(negedge clk) begin
    if (scale_valid === 1'b1 && !sb_ignore) begin
      exp_t e;
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
      $display("scale_valid cyc=%0d light_scale=%0d timeout=%0d overrun=%0d", cyc, light_scale, timeout, overrun);
      check("sb_pending", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("light_scale", 32'(light_scale), 32'(e.code));
        check("timeout_flag", 32'(timeout), 32'(e.to));
      end
    end
  end

  task automatic drive(input logic v);
    @(negedge clk);
    pwm_in = v;
    if (v && !pwm_last) begin
      if (model_on && model_meas) begin
        exp_t e;
        e.code = expected_code(hi_m, per_m);
        e.to   = 1'b0;
        sb_q.push_back(e);
      end
      model_meas = model_on;
      per_m = 0;
      hi_m  = 0;
    end
    per_m++;
    if (v) hi_m++;
    pwm_last = v;
  endtask

  task automatic pattern(input int p, input int h, input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < p; j++)
        drive(j < h);
  endtask

  task automatic hold(input logic v, input int n);
    drive(v);
    if (model_on) begin
      exp_t e;
      e.code = v ? 8'd100 : 8'd1;
      e.to   = 1'b1;
      sb_q.push_back(e);
    end
    model_meas = 1'b0;
    repeat (n - 1) drive(v);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_light_scale", 32'(light_scale), 32'd20);
    check("rst_scale_valid", 32'(scale_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Static low input from reset: a single code-1 pulse with timeout.
    begin
      exp_t e;
      e.code = 8'd1;
      e.to   = 1'b1;
      sb_q.push_back(e);
    end
    n = 0;
    while (n < TIMEOUT + 50) begin
      @(negedge clk);
      n++;
      if (scale_valid === 1'b1) break;
    end
    check("idle_timeout_latency", 32'(n), 32'(TIMEOUT + 3));
    @(negedge clk);
    check("valid_pulse_width", 32'(scale_valid), 32'd0);
    check("timeout_static", 32'(timeout), 32'd1);

    // Steady 1000/300: codes of 30 one period apart.
    pattern(1000, 300, 4);
    check("period_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd1000);
    check("code_30", 32'(light_scale), 32'd30);
    check("overrun_clean", 32'(overrun), 32'd0);
    check("timeout_cleared", 32'(timeout), 32'd0);
`ifdef LCD_PWM_RAW_EN
    check("duty_raw", 32'(duty_raw), 32'd300);
    check("period_raw", 32'(period_raw), 32'd1000);
`endif

    // Rounding boundaries around 40/50 and 90/100.
    pattern(1000, 449, 2);
    pattern(1000, 450, 2);
    pattern(1000, 949, 2);
    pattern(1000, 950, 2);
    check("code_100", 32'(light_scale), 32'd100);

    // Held high goes static at 100, then a 50% PWM recovers.
    hold(1'b1, TIMEOUT + 30);
    check("static_high_timeout", 32'(timeout), 32'd1);
    check("static_high_code", 32'(light_scale), 32'd100);
    pattern(1000, 500, 3);
    check("recover_timeout", 32'(timeout), 32'd0);
    check("recover_code_50", 32'(light_scale), 32'd50);

    // Period 8 drops snapshots; overrun sticks through a later valid 70% PWM.
    sb_ignore = 1'b1;
    model_on  = 1'b0;
    pattern(8, 6, 40);
    repeat (30) drive(1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    sb_ignore = 1'b0;
    model_on  = 1'b1;
    hold(1'b0, TIMEOUT + 30);
    pattern(1000, 700, 3);
    check("code_70", 32'(light_scale), 32'd70);
    check("overrun_sticky", 32'(overrun), 32'd1);

    // Reset lands while the last 700 period is being quantized.
    model_on = 1'b0;
    drive(1'b1);
    drive(1'b1);
    drive(1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midq_light_scale", 32'(light_scale), 32'd20);
    check("midq_scale_valid", 32'(scale_valid), 32'd0);
    check("midq_timeout", 32'(timeout), 32'd0);
    check("midq_overrun", 32'(overrun), 32'd0);
`ifdef LCD_PWM_RAW_EN
    check("midq_duty_raw", 32'(duty_raw), 32'd0);
    check("midq_period_raw", 32'(period_raw), 32'd0);
`endif
    reset      = 1'b0;
    pwm_in     = 1'b0;
    pwm_last   = 1'b0;
    model_meas = 1'b0;
    model_on   = 1'b1;
    repeat (40) drive(1'b0);
    check("post_reset_code", 32'(light_scale), 32'd20);

    repeat (5) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
